// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, address width and arbiter state encoding.
package vga_pkg;
   localparam int unsigned FB_W      = 640;
   localparam int unsigned FB_H      = 480;
   localparam int unsigned FB_ADDR_W = 19;
   localparam int unsigned PIX_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DISP_RD = 2'd1,
      WR      = 2'd2
   } arb_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Scan position to linear framebuffer address; row*640 built from two shifts.
module fb_addr_calc
   import vga_pkg::*;
(
   input  logic [8:0]           row,
   input  logic [9:0]           col,
   output logic [FB_ADDR_W-1:0] addr_c
);
   assign addr_c = (FB_ADDR_W'(row) << 9) + (FB_ADDR_W'(row) << 7) + FB_ADDR_W'(col);
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch always beats draw-engine writes.
// Optional stall statistics counter enabled with VGA_ARB_STATS_EN.
module vga_fb_arbiter #(
   parameter int unsigned PIX_W = vga_pkg::PIX_W_DEF,
   parameter int unsigned FB_W  = vga_pkg::FB_W,
   parameter int unsigned FB_H  = vga_pkg::FB_H
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic                          blank,
   input  logic [8:0]                    row,
   input  logic [9:0]                    col,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [vga_pkg::FB_ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]              wr_data,
   output logic [vga_pkg::FB_ADDR_W-1:0] mem_addr,
   output logic                          mem_we,
   output logic [PIX_W-1:0]              mem_wdata,
   input  logic [PIX_W-1:0]              mem_rdata,
   output logic [PIX_W-1:0]              pixel,
`ifdef VGA_ARB_STATS_EN
   output logic [15:0]                   stall_count,
`endif
   output logic                          pixel_valid
);
   import vga_pkg::FB_ADDR_W, vga_pkg::arb_state_t, vga_pkg::IDLE, vga_pkg::DISP_RD, vga_pkg::WR;

   localparam int unsigned FB_SIZE = FB_W * FB_H;

   arb_state_t           state, state_d;
   logic                 pend, pend_d;
   logic [FB_ADDR_W-1:0] mem_addr_d;
   logic                 mem_we_d;
   logic [PIX_W-1:0]     mem_wdata_d;
   logic [9:0]           col_q;
   logic                 blank_q;
   logic [FB_ADDR_W-1:0] disp_addr_c, disp_addr_q;
   logic                 trigger_c;
   logic                 in_range_c;
   logic                 rd_q;

   fb_addr_calc u_addr (
      .row    (row),
      .col    (col),
      .addr_c (disp_addr_c)
   );

   assign trigger_c  = (!blank && (col != col_q)) || (blank_q && !blank);
   assign in_range_c = 32'(wr_addr) < FB_SIZE;
   assign wr_ready   = !reset && (state == IDLE) && !trigger_c && !pend;

   // Next state and next registered memory-port values
   always_comb begin
      state_d     = state;
      pend_d      = pend;
      mem_addr_d  = mem_addr;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata;
      if (trigger_c) pend_d = 1'b1;
      case (state)
         IDLE: begin
            if (trigger_c || pend) begin
               state_d    = DISP_RD;
               pend_d     = 1'b0;
               mem_addr_d = trigger_c ? disp_addr_c : disp_addr_q;
            end else if (wr_valid) begin
               state_d     = WR;
               mem_addr_d  = wr_addr;
               mem_wdata_d = wr_data;
               mem_we_d    = in_range_c;
            end
         end
         DISP_RD: state_d = IDLE;
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         pend      <= pend_d;
         mem_addr  <= mem_addr_d;
         mem_we    <= mem_we_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   // Scan history, newest display address and read-data capture
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         col_q       <= '0;
         blank_q     <= 1'b1;
         disp_addr_q <= '0;
         rd_q        <= 1'b0;
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end else begin
         col_q       <= col;
         blank_q     <= blank;
         rd_q        <= (state == DISP_RD);
         pixel_valid <= rd_q;
         if (trigger_c) disp_addr_q <= disp_addr_c;
         if (rd_q)      pixel       <= mem_rdata;
      end
   end

`ifdef VGA_ARB_STATS_EN
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         stall_count <= '0;
      end else if (wr_valid && !wr_ready && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter; RAM model returns 8'hA5 at 646, else addr[7:0].
module tb_vga_fb_arbiter;
   logic        clk = 1'b0;
   logic        reset, blank, wr_valid, wr_ready, mem_we, pixel_valid;
   logic [8:0]  row;
   logic [9:0]  col;
   logic [18:0] wr_addr, mem_addr;
   logic [7:0]  wr_data, mem_wdata, mem_rdata, pixel;
`ifdef VGA_ARB_STATS_EN
   logic [15:0] stall_count;
`endif
   int tests = 0;
   int fails = 0;

   always #10 clk = ~clk;

   always @(posedge clk) mem_rdata <= (mem_addr == 19'd646) ? 8'hA5 : mem_addr[7:0];

   vga_fb_arbiter dut (
      .CLOCK_50    (clk),
      .reset       (reset),
      .blank       (blank),
      .row         (row),
      .col         (col),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pixel       (pixel),
`ifdef VGA_ARB_STATS_EN
      .stall_count (stall_count),
`endif
      .pixel_valid (pixel_valid)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; blank = 1'b1; wr_valid = 1'b0; row = '0; col = '0; wr_addr = '0; wr_data = '0;
      tick(3);
      #1;
      tests++; if (mem_we !== 1'b0)       begin fails++; $display("FAIL rst_we got %0b exp 0", mem_we); end
      tests++; if (mem_addr !== 19'd0)    begin fails++; $display("FAIL rst_addr got %0d exp 0", mem_addr); end
      tests++; if (mem_wdata !== 8'h00)   begin fails++; $display("FAIL rst_wdata got %h exp 00", mem_wdata); end
      tests++; if (pixel !== 8'h00)       begin fails++; $display("FAIL rst_pixel got %h exp 00", pixel); end
      tests++; if (pixel_valid !== 1'b0)  begin fails++; $display("FAIL rst_pv got %0b exp 0", pixel_valid); end
      tests++; if (wr_ready !== 1'b0)     begin fails++; $display("FAIL rst_ready got %0b exp 0", wr_ready); end
      reset = 1'b0;
      tick(1);
      #1;
      tests++; if (wr_ready !== 1'b1)     begin fails++; $display("FAIL rel_ready got %0b exp 1", wr_ready); end
      tests++; if (mem_we !== 1'b0)       begin fails++; $display("FAIL rel_we got %0b exp 0", mem_we); end
   endtask

   task automatic test_display();
      blank = 1'b0; row = 9'd1; col = 10'd5;
      tick(8);
      tests++; if (pixel !== 8'h85) begin fails++; $display("FAIL disp_first_pixel got %h exp 85", pixel); end
      col = 10'd6;
      #1;
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL disp_trig_ready got %0b exp 0", wr_ready); end
      tick(1);
      tests++; if (mem_addr !== 19'd646) begin fails++; $display("FAIL disp_addr got %0d exp 646", mem_addr); end
      tests++; if (mem_we !== 1'b0)      begin fails++; $display("FAIL disp_we got %0b exp 0", mem_we); end
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_pv_t1 got %0b exp 0", pixel_valid); end
      tick(1);
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_pv_t2 got %0b exp 0", pixel_valid); end
      tick(1);
      tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL disp_pv_t3 got %0b exp 1", pixel_valid); end
      tests++; if (pixel !== 8'hA5)      begin fails++; $display("FAIL disp_pixel got %h exp a5", pixel); end
      tick(1);
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL disp_pv_t4 got %0b exp 0", pixel_valid); end
   endtask

   task automatic test_blank_writes();
      blank = 1'b1;
      tick(2);
      wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'h3C;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (k % 2 == 0) begin
            tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL blk_ready k=%0d got %0b exp 1", k, wr_ready); end
            tests++; if (mem_we !== 1'b0)   begin fails++; $display("FAIL blk_we k=%0d got %0b exp 0", k, mem_we); end
         end else begin
            tests++; if (wr_ready !== 1'b0)   begin fails++; $display("FAIL blk_ready k=%0d got %0b exp 0", k, wr_ready); end
            tests++; if (mem_we !== 1'b1)     begin fails++; $display("FAIL blk_we k=%0d got %0b exp 1", k, mem_we); end
            tests++; if (mem_addr !== 19'd100) begin fails++; $display("FAIL blk_addr k=%0d got %0d exp 100", k, mem_addr); end
            tests++; if (mem_wdata !== 8'h3C) begin fails++; $display("FAIL blk_wdata k=%0d got %h exp 3c", k, mem_wdata); end
         end
         tick(1);
      end
      wr_valid = 1'b0;
      tick(2);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL blk_end_we got %0b exp 0", mem_we); end
   endtask

   task automatic test_write_then_display();
      blank = 1'b0;
      tick(8);
      wr_valid = 1'b1; wr_addr = 19'd200; wr_data = 8'h55;
      #1;
      tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL wd_ready got %0b exp 1", wr_ready); end
      tick(1);
      tests++; if (mem_we !== 1'b1 || mem_addr !== 19'd200) begin fails++; $display("FAIL wd_write got we=%0b addr=%0d exp we=1 addr=200", mem_we, mem_addr); end
      wr_valid = 1'b0; col = 10'd7;
      tick(1);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL wd_we_once got %0b exp 0", mem_we); end
      #1;
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL wd_pend_ready got %0b exp 0", wr_ready); end
      tick(1);
      tests++; if (mem_addr !== 19'd647 || mem_we !== 1'b0) begin fails++; $display("FAIL wd_disp got addr=%0d we=%0b exp addr=647 we=0", mem_addr, mem_we); end
      tick(1);
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL wd_pv_t3 got %0b exp 0", pixel_valid); end
      tick(1);
      tests++; if (pixel_valid !== 1'b1 || pixel !== 8'h87) begin fails++; $display("FAIL wd_pv_t4 got pv=%0b pix=%h exp pv=1 pix=87", pixel_valid, pixel); end
      tick(1);
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL wd_pv_t5 got %0b exp 0", pixel_valid); end
   endtask

   task automatic test_newest_wins();
      tick(4);
      wr_valid = 1'b1; wr_addr = 19'd10; wr_data = 8'h11;
      tick(1);
      wr_valid = 1'b0; col = 10'd8;
      tick(1);
      col = 10'd9;
      tick(1);
      tests++; if (mem_addr !== 19'd649) begin fails++; $display("FAIL nw_addr got %0d exp 649", mem_addr); end
      tick(2);
      tests++; if (pixel_valid !== 1'b1 || pixel !== 8'h89) begin fails++; $display("FAIL nw_pixel got pv=%0b pix=%h exp pv=1 pix=89", pixel_valid, pixel); end
      for (int k = 0; k < 3; k++) begin
         tick(1);
         tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL nw_extra_pv k=%0d got %0b exp 0", k, pixel_valid); end
      end
   endtask

   task automatic test_addr_range();
      blank = 1'b1;
      tick(2);
      wr_valid = 1'b1; wr_addr = 19'd307199; wr_data = 8'hEE;
      tick(1);
      tests++; if (mem_we !== 1'b1 || mem_addr !== 19'd307199) begin fails++; $display("FAIL rng_last got we=%0b addr=%0d exp we=1 addr=307199", mem_we, mem_addr); end
      wr_addr = 19'd307200;
      tick(1);
      #1;
      tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rng_ready got %0b exp 1", wr_ready); end
      tick(1);
      #1;
      tests++; if (mem_we !== 1'b0)   begin fails++; $display("FAIL rng_oob_we got %0b exp 0", mem_we); end
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rng_wr_ready got %0b exp 0", wr_ready); end
      wr_valid = 1'b0;
      tick(1);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rng_after_we got %0b exp 0", mem_we); end
   endtask

   task automatic test_reset_abort();
      wr_valid = 1'b1; wr_addr = 19'd300; wr_data = 8'h01;
      tick(1);
      tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL ab_wr_we got %0b exp 1", mem_we); end
      reset = 1'b1; wr_valid = 1'b0;
      tick(1);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL ab_wr_abort got %0b exp 0", mem_we); end
      reset = 1'b0; blank = 1'b0; row = 9'd2; col = 10'd3;
      tick(1);
      tests++; if (mem_addr !== 19'd1283) begin fails++; $display("FAIL ab_disp_addr got %0d exp 1283", mem_addr); end
      reset = 1'b1;
      tick(1);
      reset = 1'b0; blank = 1'b1;
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL ab_pv1 got %0b exp 0", pixel_valid); end
      tick(1);
      tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL ab_pv2 got %0b exp 0", pixel_valid); end
      tick(2);
   endtask

`ifdef VGA_ARB_STATS_EN
   task automatic test_stats();
      int exp_cnt;
      exp_cnt = 0;
      reset = 1'b1; tick(2); reset = 1'b0;
      tests++; if (stall_count !== 16'd0) begin fails++; $display("FAIL st_reset got %0d exp 0", stall_count); end
      blank = 1'b0; row = 9'd0; col = 10'd0; wr_valid = 1'b1; wr_addr = 19'd50; wr_data = 8'h22;
      for (int k = 0; k < 40; k++) begin
         if (k % 2 == 0) col = 10'(k);
         #1;
         if (!wr_ready) exp_cnt++;
         tick(1);
      end
      tests++; if (stall_count !== 16'(exp_cnt)) begin fails++; $display("FAIL st_line got %0d exp %0d", stall_count, exp_cnt); end
      for (int k = 0; k < 70000; k++) begin
         col = 10'(k + 1);
         tick(1);
      end
      tests++; if (stall_count !== 16'hFFFF) begin fails++; $display("FAIL st_sat got %h exp ffff", stall_count); end
      wr_valid = 1'b0; blank = 1'b1;
      tick(2);
   endtask
`endif

   initial begin
      test_reset();
      test_display();
      test_blank_writes();
      test_write_then_display();
      test_newest_wins();
      test_addr_range();
      test_reset_abort();
`ifdef VGA_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
